// File: rtl/sobel_grad_sq_if.sv
// Pixel-in / radicand-out stream bundle for the Sobel gradient stage.
// master drives pixels and observes results; slave is the gradient stage.
interface sobel_grad_sq_if;
    logic        pix_valid;
    logic [7:0]  pix_in;
    logic        sof;
    logic        r_valid;
    logic [15:0] r_out;
    logic        r_eol;
    logic        r_eof;

    modport master (
        output pix_valid, pix_in, sof,
        input  r_valid, r_out, r_eol, r_eof
    );

    modport slave (
        input  pix_valid, pix_in, sof,
        output r_valid, r_out, r_eol, r_eof
    );
endinterface

// File: rtl/sobel_grad_sq.sv
// Streaming 3x3 Sobel gradient stage. Takes one raster-order pixel per
// cycle, keeps two line buffers plus a 3x3 window, and emits the saturated
// sum of squares of the 8-bit scaled |Gx| and |Gy| as the radicand for the
// downstream square-root unit. Result lags its source pixel by 3 cycles.
module sobel_grad_sq #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    sobel_grad_sq_if.slave bus
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic          accept;
    logic [CW-1:0] col_q;
    logic [CW-1:0] cur_col;
    logic [RW-1:0] row_q;
    logic [RW-1:0] cur_row;
    logic          emit;

    logic [7:0] lb1 [IMG_W];
    logic [7:0] lb2 [IMG_W];
    logic [7:0] lb1_rd;
    logic [7:0] lb2_rd;

    logic [7:0] win [3][3];

    logic v0, eol0, eof0;
    logic v1, eol1, eof1;
    logic v2, eol2, eof2;

    logic [10:0]        gx_pos, gx_neg, gy_pos, gy_neg;
    logic signed [10:0] gx_q, gy_q;
    logic [10:0]        gx_abs, gy_abs;
    logic [7:0]         ax, ay;
    logic [15:0]        sq_x_q, sq_y_q;
    logic [16:0]        sum;

    assign accept = bus.pix_valid;

    // Position of the pixel on the bus; sof overrides the running counters.
    always_comb begin
        cur_col = col_q;
        cur_row = row_q;
        if (bus.sof) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    assign emit   = accept && (cur_row >= RW'(2)) && (cur_col >= CW'(2));
    assign lb1_rd = lb1[cur_col];
    assign lb2_rd = lb2[cur_col];

    // Raster position of the next pixel; wraps at end of frame without sof.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (cur_col == COL_LAST) begin
                col_q <= '0;
                row_q <= (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
            end else begin
                col_q <= cur_col + CW'(1);
                row_q <= cur_row;
            end
        end
    end

    // Line buffers: lb1 holds the previous row, lb2 the one before; not reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[cur_col] <= bus.pix_in;
            lb2[cur_col] <= lb1_rd;
        end
    end

    // 3x3 window shifts left; new column enters at c=2, oldest row at r=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    win[r][c] <= '0;
                end
            end
        end else if (accept) begin
            for (int r = 0; r < 3; r++) begin
                win[r][0] <= win[r][1];
                win[r][1] <= win[r][2];
            end
            win[0][2] <= lb2_rd;
            win[1][2] <= lb1_rd;
            win[2][2] <= bus.pix_in;
        end
    end

    // Stage-0 tags travel alongside the data through the pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v0   <= 1'b0;
            eol0 <= 1'b0;
            eof0 <= 1'b0;
        end else begin
            v0   <= emit;
            eol0 <= cur_col == COL_LAST;
            eof0 <= (cur_col == COL_LAST) && (cur_row == ROW_LAST);
        end
    end

    // Weighted column/row sums of the window; each fits in 10 bits unsigned.
    always_comb begin
        gx_pos = {3'b0, win[0][2]} + {2'b0, win[1][2], 1'b0} + {3'b0, win[2][2]};
        gx_neg = {3'b0, win[0][0]} + {2'b0, win[1][0], 1'b0} + {3'b0, win[2][0]};
        gy_pos = {3'b0, win[2][0]} + {2'b0, win[2][1], 1'b0} + {3'b0, win[2][2]};
        gy_neg = {3'b0, win[0][0]} + {2'b0, win[0][1], 1'b0} + {3'b0, win[0][2]};
    end

    // Stage 1: register signed Gx/Gy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gx_q <= '0;
            gy_q <= '0;
            v1   <= 1'b0;
            eol1 <= 1'b0;
            eof1 <= 1'b0;
        end else begin
            v1   <= v0;
            eol1 <= eol0;
            eof1 <= eof0;
            if (v0) begin
                gx_q <= signed'(gx_pos - gx_neg);
                gy_q <= signed'(gy_pos - gy_neg);
            end
        end
    end

    // Magnitude scaled to 8 bits by truncation; |G| <= 1020 so bit 10 is clear.
    always_comb begin
        gx_abs = gx_q[10] ? 11'(-gx_q) : 11'(gx_q);
        gy_abs = gy_q[10] ? 11'(-gy_q) : 11'(gy_q);
        ax     = 8'(gx_abs >> 2);
        ay     = 8'(gy_abs >> 2);
    end

    // Stage 2: register the two squares.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_x_q <= '0;
            sq_y_q <= '0;
            v2     <= 1'b0;
            eol2   <= 1'b0;
            eof2   <= 1'b0;
        end else begin
            v2   <= v1;
            eol2 <= eol1;
            eof2 <= eof1;
            if (v1) begin
                sq_x_q <= {8'd0, ax} * {8'd0, ax};
                sq_y_q <= {8'd0, ay} * {8'd0, ay};
            end
        end
    end

    assign sum = {1'b0, sq_x_q} + {1'b0, sq_y_q};

    // Stage 3: saturated radicand and flags; data holds while r_valid is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.r_valid <= 1'b0;
            bus.r_out   <= '0;
            bus.r_eol   <= 1'b0;
            bus.r_eof   <= 1'b0;
        end else begin
            bus.r_valid <= v2;
            if (v2) begin
                bus.r_out <= sum[16] ? 16'hFFFF : sum[15:0];
                bus.r_eol <= eol2;
                bus.r_eof <= eof2;
            end
        end
    end

endmodule

// File: tb/tb_sobel_grad_sq.sv
// Directed bench for sobel_grad_sq on an 8x4 frame: table of whole-frame
// images with hand-computed result rows, plus sof and reset disruptions.
module tb_sobel_grad_sq;

    localparam int W = 8;
    localparam int H = 4;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    sobel_grad_sq_if bus ();

    sobel_grad_sq #(.IMG_W(W), .IMG_H(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] val;
        logic        eol;
        logic        eof;
        int          cyc;
    } res_t;

    typedef struct {
        int           kind;
        bit           use_sof;
        bit           gaps;
        logic [191:0] exp;
    } vec_t;

    res_t exp_q[$];
    vec_t vecs[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    // kind: 0 flat, 1 vertical step, 2 dark top row/left column,
    // 3 rising ramp, 4 falling ramp, 5 diagonal ramp 9*col+3*row
    function automatic logic [7:0] pix_val(input int kind, input int r, input int c);
        case (kind)
            0:       return 8'd100;
            1:       return (c < 4) ? 8'd0 : 8'd255;
            2:       return (r == 0 || c == 0) ? 8'd0 : 8'd255;
            3:       return 8'(c);
            4:       return 8'(7 - c);
            default: return 8'(9 * c + 3 * r);
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive_range(input int kind, input int n_pix, input bit use_sof,
                               input bit gaps, input logic [191:0] exp, input bit record);
        int k;
        k = 0;
        for (int i = 0; i < n_pix; i++) begin
            int r;
            int c;
            res_t e;
            r = i / W;
            c = i % W;
            if (gaps && i > 0 && $urandom_range(0, 2) == 0) begin
                bus.pix_valid = 1'b0;
                bus.sof       = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            bus.pix_valid = 1'b1;
            bus.pix_in    = pix_val(kind, r, c);
            bus.sof       = use_sof && (i == 0);
            if (record && r >= 2 && c >= 2) begin
                e.val = exp[k*16 +: 16];
                e.eol = (c == W - 1);
                e.eof = (c == W - 1) && (r == H - 1);
                e.cyc = cyc + 1;
                exp_q.push_back(e);
                k++;
            end
            @(posedge clk);
            #1;
        end
        bus.pix_valid = 1'b0;
        bus.sof       = 1'b0;
    endtask

    task automatic watch(input int tag, input int n_expect, input int budget);
        int got;
        got = 0;
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (bus.r_valid) begin
                got++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_result[%0d]: got r_out %0h, expected no result", tag, bus.r_out);
                end else begin
                    res_t e;
                    e = exp_q.pop_front();
                    chk($sformatf("r_out[%0d]#%0d", tag, got), 32'(bus.r_out), 32'(e.val));
                    chk($sformatf("r_eol[%0d]#%0d", tag, got), 32'(bus.r_eol), 32'(e.eol));
                    chk($sformatf("r_eof[%0d]#%0d", tag, got), 32'(bus.r_eof), 32'(e.eof));
                    chk($sformatf("latency[%0d]#%0d", tag, got), 32'(cyc), 32'(e.cyc + 3));
                end
            end
        end
        chk($sformatf("result_count[%0d]", tag), 32'(got), 32'(n_expect));
        exp_q.delete();
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        bus.pix_valid = 1'b0;
        bus.pix_in    = 8'd0;
        bus.sof       = 1'b0;

        // Result order is row-major over window centres (1..2, 1..6); k=0 in the LSBs.
        vecs[0] = '{kind: 0, use_sof: 1'b1, gaps: 1'b0, exp: '0};
        vecs[1] = '{kind: 1, use_sof: 1'b0, gaps: 1'b0,
                    exp: {2{16'h0000, 16'h0000, 16'hFE01, 16'hFE01, 16'h0000, 16'h0000}}};
        // Centre (1,1) saturates; the dark top row and left column also give
        // full-scale single-axis edges along centre row 1 and at centre (2,1).
        vecs[2] = '{kind: 2, use_sof: 1'b1, gaps: 1'b0,
                    exp: {{5{16'h0000}}, {6{16'hFE01}}, 16'hFFFF}};
        vecs[3] = '{kind: 3, use_sof: 1'b1, gaps: 1'b0, exp: {12{16'h0004}}};
        vecs[4] = '{kind: 4, use_sof: 1'b0, gaps: 1'b0, exp: {12{16'h0004}}};
        vecs[5] = '{kind: 5, use_sof: 1'b1, gaps: 1'b0, exp: {12{16'h0168}}};
        vecs[6] = '{kind: 0, use_sof: 1'b1, gaps: 1'b1, exp: '0};
        vecs[7] = '{kind: 5, use_sof: 1'b0, gaps: 1'b1, exp: {12{16'h0168}}};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_r_valid", 32'(bus.r_valid), 32'd0);
        chk("reset_r_out",   32'(bus.r_out),   32'd0);
        chk("reset_r_eol",   32'(bus.r_eol),   32'd0);
        chk("reset_r_eof",   32'(bus.r_eof),   32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int v = 0; v < 8; v++) begin
            fork
                drive_range(vecs[v].kind, W * H, vecs[v].use_sof, vecs[v].gaps, vecs[v].exp, 1'b1);
                watch(v, 12, 200);
            join
        end

        // sof at (2,5) of a step frame: its three results still drain, then a full flat frame.
        fork
            begin
                drive_range(1, 2 * W + 5, 1'b1, 1'b0, vecs[1].exp, 1'b1);
                drive_range(0, W * H, 1'b1, 1'b0, '0, 1'b1);
            end
            watch(100, 15, 250);
        join

        // Reset mid-row with a saturated result on the outputs and three more in flight.
        drive_range(2, 2 * W + 6, 1'b1, 1'b0, '0, 1'b0);
        chk("pre_reset_r_valid", 32'(bus.r_valid), 32'd1);
        chk("pre_reset_r_out",   32'(bus.r_out),   32'hFFFF);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_r_valid", 32'(bus.r_valid), 32'd0);
        chk("mid_reset_r_out",   32'(bus.r_out),   32'd0);
        chk("mid_reset_r_eol",   32'(bus.r_eol),   32'd0);
        chk("mid_reset_r_eof",   32'(bus.r_eof),   32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("held_reset_r_valid", 32'(bus.r_valid), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // No sof: the first pixel after reset must land at (0,0).
        fork
            drive_range(0, W * H, 1'b0, 1'b0, '0, 1'b1);
            watch(101, 12, 200);
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
